// File: rtl/moi_reader.sv
// moi_reader: reads the four action banks for one state and reduces them
// to the max Q, its action index, and the Q of a requested action.
module moi_reader #(
  parameter int RD_LAT = 1,
  parameter int DW     = 32,
  parameter int SW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] S,
  input  logic [1:0]    A_sel,
  output logic [31:0]   RD_ADDR,
  output logic          en0,
  output logic          en1,
  output logic          en2,
  output logic          en3,
  input  logic [DW-1:0] dout0,
  input  logic [DW-1:0] dout1,
  input  logic [DW-1:0] dout2,
  input  logic [DW-1:0] dout3,
  output logic          out_valid,
  output logic [DW-1:0] Q_max,
  output logic [1:0]    A_max,
  output logic [DW-1:0] Q_sel
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CMP,
    FIN
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t state;
  state_t state_nx;

  logic       rd_en;
  logic       accept;
  logic       last_wait;
  logic [1:0] cnt;
  logic [1:0] a_sel_q;

  logic signed [DW-1:0] w0;
  logic signed [DW-1:0] w1;
  logic signed [DW-1:0] w2;
  logic signed [DW-1:0] w3;

  logic signed [DW-1:0] p0_q;
  logic signed [DW-1:0] p1_q;
  logic                 p0_i;
  logic                 p1_i;

  logic signed [DW-1:0] fin_q;
  logic [1:0]           fin_i;
  logic [DW-1:0]        sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = RD;
      end
      RD: begin
        rd_en    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) state_nx = CMP;
      end
      CMP: state_nx = FIN;
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = req_valid & req_ready;
  assign last_wait = (state == WAIT) && (cnt == 2'd0);

  assign en0 = rd_en;
  assign en1 = rd_en;
  assign en2 = rd_en;
  assign en3 = rd_en;

  // Second tree level; strict greater-than keeps the lower index on ties.
  always_comb begin
    if (p1_q > p0_q) begin
      fin_q = p1_q;
      fin_i = {1'b1, p1_i};
    end else begin
      fin_q = p0_q;
      fin_i = {1'b0, p0_i};
    end
  end

  always_comb begin
    case (a_sel_q)
      2'd0:    sel_q = w0;
      2'd1:    sel_q = w1;
      2'd2:    sel_q = w2;
      default: sel_q = w3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD_ADDR   <= '0;
      a_sel_q   <= '0;
      cnt       <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      p0_q      <= '0;
      p0_i      <= 1'b0;
      p1_q      <= '0;
      p1_i      <= 1'b0;
      out_valid <= 1'b0;
      Q_max     <= '0;
      A_max     <= '0;
      Q_sel     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        RD_ADDR <= 32'({S, 2'b00});
        a_sel_q <= A_sel;
      end
      if (state == RD) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (last_wait) begin
        w0 <= dout0;
        w1 <= dout1;
        w2 <= dout2;
        w3 <= dout3;
      end
      if (state == CMP) begin
        if (w1 > w0) begin
          p0_q <= w1;
          p0_i <= 1'b1;
        end else begin
          p0_q <= w0;
          p0_i <= 1'b0;
        end
        if (w3 > w2) begin
          p1_q <= w3;
          p1_i <= 1'b1;
        end else begin
          p1_q <= w2;
          p1_i <= 1'b0;
        end
      end
      if (state == FIN) begin
        Q_max     <= fin_q;
        A_max     <= fin_i;
        Q_sel     <= sel_q;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moi_reader.sv
// tb_moi_reader: directed checks of moi_reader with RD_LAT=1 and RD_LAT=3
// instances fed by a latency-accurate bank model.
module tb_moi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv1, rv3;
  logic [11:0] S;
  logic [1:0]  A_sel;
  logic        rdy1, rdy3, ov1, ov3;
  logic [31:0] addr1, addr3, qm1, qm3, qs1, qs3;
  logic [1:0]  am1, am3;
  logic [3:0]  e1, e3;
  logic [31:0] bank_val [4];
  logic [31:0] d1 [4];
  logic [31:0] d3 [4];
  logic        v1;
  logic [2:0]  v3;

  int checks = 0;
  int failures = 0;

  moi_reader #(.RD_LAT(1), .DW(32), .SW(12)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rdy1),
    .S(S), .A_sel(A_sel), .RD_ADDR(addr1),
    .en0(e1[0]), .en1(e1[1]), .en2(e1[2]), .en3(e1[3]),
    .dout0(d1[0]), .dout1(d1[1]), .dout2(d1[2]), .dout3(d1[3]),
    .out_valid(ov1), .Q_max(qm1), .A_max(am1), .Q_sel(qs1)
  );

  moi_reader #(.RD_LAT(3), .DW(32), .SW(12)) u3 (
    .clk(clk), .rst(rst),
    .req_valid(rv3), .req_ready(rdy3),
    .S(S), .A_sel(A_sel), .RD_ADDR(addr3),
    .en0(e3[0]), .en1(e3[1]), .en2(e3[2]), .en3(e3[3]),
    .dout0(d3[0]), .dout1(d3[1]), .dout2(d3[2]), .dout3(d3[3]),
    .out_valid(ov3), .Q_max(qm3), .A_max(am3), .Q_sel(qs3)
  );

  // Banks present data only in the valid window; otherwise a huge
  // positive value that would win the max if captured at the wrong edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v3 <= '0;
    end else begin
      v1 <= e1[0];
      v3 <= {v3[1:0], e3[0]};
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      d1[k] = v1 ? bank_val[k] : 32'h7FFF_FFFF;
      d3[k] = v3[2] ? bank_val[k] : 32'h7FFF_FFFF;
    end
  end

  task automatic set_banks(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
    bank_val[0] = b0;
    bank_val[1] = b1;
    bank_val[2] = b2;
    bank_val[3] = b3;
  endtask

  task automatic req1(input logic [11:0] s, input logic [1:0] a,
                      output int lat);
    @(negedge clk);
    S = s;
    A_sel = a;
    rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    lat = 0;
    while (ov1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (rdy1 !== 1'b1) begin
      failures++; $display("FAIL rst_ready got=%b exp=1", rdy1);
    end
    checks++;
    if ({ov1, e1, am1} !== 7'd0) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=0", {ov1, e1, am1});
    end
    checks++;
    if ({addr1, qm1, qs1} !== 96'd0) begin
      failures++; $display("FAIL rst_data got=%h exp=0", {addr1, qm1, qs1});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    set_banks(32'd10, 32'd40, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    S = 12'h005;
    A_sel = 2'd2;
    rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    checks++;
    if (addr1 !== 32'h14) begin
      failures++; $display("FAIL basic_addr got=%h exp=00000014", addr1);
    end
    checks++;
    if (e1 !== 4'hF || rdy1 !== 1'b0) begin
      failures++; $display("FAIL basic_en got=%h/%b exp=f/0", e1, rdy1);
    end
    @(posedge clk); #1;
    checks++;
    if (e1 !== 4'h0) begin
      failures++; $display("FAIL basic_en_drop got=%h exp=0", e1);
    end
    lat = 1;
    while (ov1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL basic_lat got=%0d exp=4", lat);
    end
    checks++;
    if (qm1 !== 32'd40 || am1 !== 2'd1) begin
      failures++; $display("FAIL basic_max got=%h/%0d exp=00000028/1", qm1, am1);
    end
    checks++;
    if (qs1 !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL basic_sel got=%h exp=fffffffd", qs1);
    end
    @(posedge clk); #1;
    checks++;
    if (ov1 !== 1'b0 || qm1 !== 32'd40) begin
      failures++; $display("FAIL basic_pulse got=%b/%h exp=0/00000028", ov1, qm1);
    end
  endtask

  task automatic test_tie;
    int lat;
    set_banks(32'h64, 32'h64, 32'h64, 32'h64);
    req1(12'h010, 2'd3, lat);
    checks++;
    if (lat !== 4 || qm1 !== 32'h64 || am1 !== 2'd0 || qs1 !== 32'h64) begin
      failures++;
      $display("FAIL tie_all got=%0d/%h/%0d/%h exp=4/00000064/0/00000064",
               lat, qm1, am1, qs1);
    end
    set_banks(32'd5, 32'd9, 32'd9, 32'd1);
    req1(12'h011, 2'd0, lat);
    checks++;
    if (qm1 !== 32'd9 || am1 !== 2'd1 || qs1 !== 32'd5) begin
      failures++;
      $display("FAIL tie_pair got=%h/%0d/%h exp=00000009/1/00000005",
               qm1, am1, qs1);
    end
  endtask

  task automatic test_signed;
    int lat;
    set_banks(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFE);
    req1(12'h020, 2'd2, lat);
    checks++;
    if (qm1 !== 32'hFFFF_FFFF || am1 !== 2'd1 || qs1 !== 32'h8000_0001) begin
      failures++;
      $display("FAIL signed_neg got=%h/%0d/%h exp=ffffffff/1/80000001",
               qm1, am1, qs1);
    end
    set_banks(32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    req1(12'h021, 2'd1, lat);
    checks++;
    if (qm1 !== 32'hFFFF_FFFF || am1 !== 2'd3 || qs1 !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL signed_b3 got=%h/%0d/%h exp=ffffffff/3/fffffffa",
               qm1, am1, qs1);
    end
    set_banks(32'd1, 32'd2, 32'h7FFF_FFF0, 32'd3);
    req1(12'h022, 2'd3, lat);
    checks++;
    if (qm1 !== 32'h7FFF_FFF0 || am1 !== 2'd2 || qs1 !== 32'd3) begin
      failures++;
      $display("FAIL signed_b2 got=%h/%0d/%h exp=7ffffff0/2/00000003",
               qm1, am1, qs1);
    end
  endtask

  task automatic test_addr_bound;
    int lat;
    set_banks(32'd3, 32'd8, 32'd6, 32'd2);
    req1(12'hFFF, 2'd1, lat);
    checks++;
    if (addr1 !== 32'h0000_3FFC || lat !== 4) begin
      failures++; $display("FAIL addr_max got=%h/%0d exp=00003ffc/4", addr1, lat);
    end
    checks++;
    if (qm1 !== 32'd8 || am1 !== 2'd1 || qs1 !== 32'd8) begin
      failures++; $display("FAIL addr_res got=%h/%0d/%h exp=8/1/8", qm1, am1, qs1);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    logic seen;
    set_banks(32'd11, 32'd12, 32'd13, 32'd14);
    @(negedge clk);
    S = 12'h003;
    A_sel = 2'd1;
    rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({ov1, e1, am1} !== 7'd0) begin
      failures++; $display("FAIL abort_ctrl got=%b exp=0", {ov1, e1, am1});
    end
    checks++;
    if ({addr1, qm1, qs1} !== 96'd0) begin
      failures++; $display("FAIL abort_data got=%h exp=0", {addr1, qm1, qs1});
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov1 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || rdy1 !== 1'b1) begin
      failures++; $display("FAIL abort_quiet got=%b/%b exp=0/1", seen, rdy1);
    end
    @(negedge clk);
    S = 12'h004;
    rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (e1 !== 4'h0) begin
      failures++; $display("FAIL abort_en got=%h exp=0", e1);
    end
    @(negedge clk);
    rst = 1'b1;
    set_banks(32'd1, 32'd5, 32'd2, 32'd3);
    req1(12'h006, 2'd3, lat);
    checks++;
    if (lat !== 4 || addr1 !== 32'h18 || qm1 !== 32'd5 || am1 !== 2'd1 ||
        qs1 !== 32'd3) begin
      failures++;
      $display("FAIL abort_after got=%0d/%h/%h/%0d/%h exp=4/18/5/1/3",
               lat, addr1, qm1, am1, qs1);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int busy;
    set_banks(32'd1, 32'd2, 32'd3, 32'd4);
    @(negedge clk);
    S = 12'h001;
    A_sel = 2'd0;
    rv1 = 1'b1;
    @(posedge clk); #1;
    S = 12'h002;
    A_sel = 2'd3;
    busy = 0;
    lat = 0;
    while (ov1 !== 1'b1 && lat < 20) begin
      if (rdy1 === 1'b0) busy++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || busy !== 4 || rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy got=%0d/%0d/%b exp=4/4/1", lat, busy, rdy1);
    end
    checks++;
    if (qm1 !== 32'd4 || am1 !== 2'd3 || qs1 !== 32'd1) begin
      failures++; $display("FAIL b2b_first got=%h/%0d/%h exp=4/3/1", qm1, am1, qs1);
    end
    set_banks(32'd9, 32'd8, 32'd7, 32'd6);
    @(posedge clk); #1;
    rv1 = 1'b0;
    checks++;
    if (addr1 !== 32'h8 || ov1 !== 1'b0 || e1 !== 4'hF) begin
      failures++;
      $display("FAIL b2b_accept got=%h/%b/%h exp=00000008/0/f", addr1, ov1, e1);
    end
    lat = 0;
    while (ov1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || qm1 !== 32'd9 || am1 !== 2'd0 || qs1 !== 32'd6) begin
      failures++;
      $display("FAIL b2b_second got=%0d/%h/%0d/%h exp=4/9/0/6", lat, qm1, am1, qs1);
    end
  endtask

  task automatic test_rdlat3;
    int lat;
    set_banks(32'd10, 32'd40, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    S = 12'h005;
    A_sel = 2'd2;
    rv3 = 1'b1;
    @(posedge clk); #1;
    rv3 = 1'b0;
    checks++;
    if (addr3 !== 32'h14 || e3 !== 4'hF) begin
      failures++; $display("FAIL lat3_addr got=%h/%h exp=00000014/f", addr3, e3);
    end
    lat = 0;
    while (ov3 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 6) begin
      failures++; $display("FAIL lat3_lat got=%0d exp=6", lat);
    end
    checks++;
    if (qm3 !== 32'd40 || am3 !== 2'd1 || qs3 !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL lat3_res got=%h/%0d/%h exp=00000028/1/fffffffd",
               qm3, am3, qs3);
    end
  endtask

  initial begin
    rst = 1'b0;
    rv1 = 1'b0;
    rv3 = 1'b0;
    S = '0;
    A_sel = '0;
    set_banks(32'd0, 32'd0, 32'd0, 32'd0);
    test_reset;
    test_basic;
    test_tie;
    test_signed;
    test_addr_bound;
    test_reset_abort;
    test_back_to_back;
    test_rdlat3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
